// File: rtl/mem_arbiter.sv
// Fetch/load-store arbiter onto one in-order memory port.
// LSU has priority; a starvation counter forces fetch through.
module mem_arbiter #(
  parameter int OUTST      = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [3:0]  ls_be_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        fetch_stall_o,
  output logic        err_o
);

  localparam int PW = (OUTST > 1) ? $clog2(OUTST) : 1;
  localparam int CW = $clog2(OUTST + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0]    cnt;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [OUTST-1:0] own_q;
  logic [SW-1:0]    starve_cnt;
  logic             err_q;

  logic full;
  logic empty;
  logic starved;
  logic fetch_sel;
  logic ls_sel;
  logic push;
  logic pop;
  logic head;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == CW'(OUTST));
  assign empty   = (cnt == '0);
  assign starved = (starve_cnt == SW'(STARVE_MAX));

  assign fetch_sel = if_req_i & (~ls_req_i | starved);
  assign ls_sel    = ls_req_i & ~fetch_sel;

  // Gated by rst_i so nothing is offered or accepted while in reset.
  assign mem_req_o = (if_req_i | ls_req_i) & ~full & ~rst_i;
  assign push      = mem_req_o & mem_gnt_i;
  assign if_gnt_o  = push & fetch_sel;
  assign ls_gnt_o  = push & ls_sel;

  assign mem_we_o    = ls_sel & ls_we_i;
  assign mem_be_o    = fetch_sel ? 4'hF : ls_be_i;
  assign mem_addr_o  = fetch_sel ? if_addr_i : ls_addr_i;
  assign mem_wdata_o = ls_sel ? ls_wdata_i : '0;

  assign pop         = mem_rvalid_i & ~empty & ~rst_i;
  assign head        = own_q[rptr];
  assign if_rvalid_o = pop & ~head;
  assign ls_rvalid_o = pop & head;
  assign if_rdata_o  = mem_rdata_i;
  assign ls_rdata_o  = mem_rdata_i;

  assign fetch_stall_o = if_req_i & ~if_gnt_o;
  assign err_o         = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      own_q <= '0;
    end else begin
      if (push) begin
        own_q[wptr] <= ls_sel;
        wptr        <= nxt(wptr);
      end
      if (pop) begin
        rptr <= nxt(rptr);
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (if_req_i & ~if_gnt_o) begin
      if (!starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // A response with nothing outstanding is dropped and flagged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (mem_rvalid_i & empty) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: OUTST, default 2, max outstanding granted-but-unanswered transactions; STARVE_MAX, default 8, consecutive fetch-denied cycles before fetch is forced to win.
REQ-002 The block SHALL use one clock, and its reset SHALL be asynchronous and active-high.
REQ-003 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk_i  in  1  clock, rising edge
- rst_i  in  1  async active-high reset
- if_req_i  in  1  fetch request
- if_addr_i  in  32  fetch byte address
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch read data valid
- if_rdata_o  out  32  fetch read data
- ls_req_i  in  1  load/store request
- ls_we_i  in  1  1 = store
- ls_be_i  in  4  store byte enables
- ls_addr_i  in  32  load/store byte address
- ls_wdata_i  in  32  store data
- ls_gnt_o  out  1  load/store request accepted
- ls_rvalid_o  out  1  load data valid / store ack
- ls_rdata_o  out  32  load data
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_be_o  out  4  memory byte enables
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid, in order
- mem_rdata_i  in  32  memory response data
- fetch_stall_o  out  1  fetch waiting; drives pipeline stall
- err_o  out  1  sticky: response with no outstanding entry

Function
REQ-004 Acceptance SHALL occur only on a cycle with mem_req_o=1 and mem_gnt_i=1; requesters SHALL hold req and payload stable until their gnt.
REQ-005 mem_req_o SHALL equal (if_req_i | ls_req_i) & ~full; full means OUTST entries outstanding.
REQ-006 Selection SHALL be combinational: LSU wins when both request, unless starve_cnt == STARVE_MAX, then fetch wins.
REQ-007 mem_* payload SHALL mux from the selected requester; for fetch, mem_we_o=0 and mem_be_o=4'hF.
REQ-008 if_gnt_o SHALL equal mem_gnt_i & mem_req_o & fetch_selected; ls_gnt_o likewise for LSU; both SHALL never be 1 in the same cycle.
REQ-009 starve_cnt (width clog2(STARVE_MAX+1)) SHALL increment on cycles with if_req_i=1 and if_gnt_o=0, saturating at STARVE_MAX, and clear to 0 on if_gnt_o=1 or if_req_i=0.
REQ-010 On each acceptance the owner ID (0=fetch, 1=LSU) SHALL be pushed into an OUTST-deep in-order FIFO.
REQ-011 On mem_rvalid_i=1 the head SHALL be popped and mem_rdata_i routed combinationally to the owner's rdata with that owner's rvalid=1; the other rvalid SHALL be 0.
REQ-012 Push and pop in the same cycle SHALL leave the count unchanged and SHALL be legal when full; mem_req_o still follows REQ-005 using the registered count.
REQ-013 A response SHALL arrive no earlier than the cycle after its acceptance; same-cycle response is out of scope.
REQ-014 mem_rvalid_i with the FIFO empty SHALL be dropped (both rvalids 0) and SHALL set err_o, which holds until reset.
REQ-015 fetch_stall_o SHALL equal if_req_i & ~if_gnt_o.
REQ-016 Read/write pointers SHALL wrap modulo OUTST.

Reset
REQ-017 rst_i=1 SHALL immediately clear the FIFO count and pointers, starve_cnt, and err_o; mem_req_o, if_gnt_o, ls_gnt_o, if_rvalid_o, and ls_rvalid_o SHALL be 0 while reset is held.
REQ-018 Responses for transactions accepted before a mid-operation reset that arrive after reset deassertion SHALL be treated per REQ-014.

Verification
REQ-019 Simultaneous if_req, ls_req (load 0x100), mem_gnt=1 -> ls_gnt=1, if_gnt=0, mem_addr=0x100, fetch_stall=1.
REQ-020 ls_req held high with continuous gnt, fetch requesting -> if_gnt=1 on the 9th fetch-request cycle (starve_cnt reaches 8), then starve_cnt=0.
REQ-021 Two accepts (fetch, LSU), memory answers with 0xAAAA0000 then 0x5555FFFF -> if_rdata=0xAAAA0000 first, ls_rdata=0x5555FFFF second, in order.
REQ-022 OUTST=2 full, requests pending -> mem_req=0; same cycle as rvalid -> mem_req stays 0; the next cycle mem_req=1.
REQ-023 Stray mem_rvalid with the FIFO empty -> no rvalid out, err_o=1 sticky; rst_i pulse -> err_o=0.
REQ-024 Assert rst_i with one transaction outstanding, release, then mem_rvalid -> response dropped, err_o=1.
